// File: rtl/obstacle_sequencer.sv
// -----------------------------------------------------------------------------
// obstacle_sequencer
//
// Game-level scheduler for the obstacle modules. It owns the shared `selected`
// code and the one-cycle `start` pulse that launches the obstacle whose code
// matches. Between obstacles it waits a fixed quiet gap. It picks each next
// obstacle from an 8-bit LFSR and never repeats the previous code. It counts
// completed obstacles up to a win, and aborts an obstacle that never
// acknowledges or never finishes.
//
// Ports:
//   pclk              clock
//   rst               synchronous reset, active-high
//   play_selected     game session active
//   menu_on           menu displayed; aborts play
//   obstacle_done     OR of all obstacle done outputs
//   obstacle_working  OR of all obstacle working outputs
//   selected[3:0]     code of the current obstacle
//   start             one-cycle launch pulse for the selected obstacle
//   round[7:0]        obstacles completed in this game
//   busy              high in every state except IDLE and WON
//   game_won          high while in WON
//   timeout_err       sticky ack/run timeout flag, cleared when a game starts
// -----------------------------------------------------------------------------
module obstacle_sequencer #(
    parameter int         NUM_OBSTACLES  = 4,
    parameter int         ROUNDS         = 8,
    parameter int         GAP_CYCLES     = 40_000_000,
    parameter int         ACK_CYCLES     = 16,
    parameter int         TIMEOUT_CYCLES = 650_000_000,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       play_selected,
    input  logic       menu_on,
    input  logic       obstacle_done,
    input  logic       obstacle_working,
    output logic [3:0] selected,
    output logic       start,
    output logic [7:0] round,
    output logic       busy,
    output logic       game_won,
    output logic       timeout_err
);

    localparam logic [3:0]  CODE_MASK  = 4'(NUM_OBSTACLES - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0]  SEED_VALUE = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [7:0]  ROUNDS_WIN = 8'(ROUNDS);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);
    localparam logic [31:0] ACK_LAST   = 32'(ACK_CYCLES - 1);
    localparam logic [31:0] RUN_LAST   = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GAP,
        ST_START,
        ST_ACK,
        ST_RUN,
        ST_WON
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] count_reg;
    logic [31:0] count_next;
    logic [31:0] count_inc;
    logic [7:0]  lfsr_reg;
    logic [7:0]  lfsr_next;
    logic [3:0]  selected_reg;
    logic [3:0]  selected_next;
    logic [7:0]  round_reg;
    logic [7:0]  round_next;
    logic [7:0]  round_inc;
    logic        timeout_reg;
    logic        timeout_next;
    logic        start_reg;
    logic        busy_reg;
    logic        won_reg;

    logic        abort;
    logic [3:0]  raw_code;
    logic [3:0]  bumped_code;
    logic [3:0]  candidate;

    // -------------------------------------------------------------------------
    // LFSR: Fibonacci, shifts left every cycle, taps 7,5,4,3 feed bit 0.
    // -------------------------------------------------------------------------
    assign lfsr_next[0] = lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3];

    genvar gi;
    generate
        for (gi = 1; gi < 8; gi++) begin : g_lfsr_shift
            assign lfsr_next[gi] = lfsr_reg[gi - 1];
        end
    endgenerate

    // Candidate code: masked low nibble, bumped by one if it would repeat the
    // obstacle that just ran. With a single obstacle the repeat is unavoidable.
    assign raw_code    = lfsr_reg[3:0] & CODE_MASK;
    assign bumped_code = (raw_code + 4'd1) & CODE_MASK;
    assign candidate   = ((NUM_OBSTACLES > 1) && (raw_code == selected_reg))
                         ? bumped_code : raw_code;

    assign abort     = menu_on | ~play_selected;
    assign count_inc = (count_reg == 32'hFFFF_FFFF) ? count_reg : count_reg + 32'd1;
    assign round_inc = round_reg + 8'd1;

    // -------------------------------------------------------------------------
    // State register and all registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            count_reg    <= '0;
            lfsr_reg     <= SEED_VALUE;
            selected_reg <= '0;
            round_reg    <= '0;
            timeout_reg  <= 1'b0;
            start_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            won_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            count_reg    <= count_next;
            lfsr_reg     <= lfsr_next;
            selected_reg <= selected_next;
            round_reg    <= round_next;
            timeout_reg  <= timeout_next;
            // Outputs are decoded from the next state so they line up with
            // the state they describe rather than lagging it by a cycle.
            start_reg    <= (state_next == ST_START);
            busy_reg     <= (state_next != ST_IDLE) && (state_next != ST_WON);
            won_reg      <= (state_next == ST_WON);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        count_next    = count_inc;
        selected_next = selected_reg;
        round_next    = round_reg;
        timeout_next  = timeout_reg;

        // Abort outranks any done or timeout arriving in the same cycle.
        if ((state_reg != ST_IDLE) && abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!abort) begin
                        state_next   = ST_GAP;
                        timeout_next = 1'b0;
                    end
                end
                ST_GAP: begin
                    if (count_reg == GAP_LAST) begin
                        state_next    = ST_START;
                        selected_next = candidate;
                    end
                end
                ST_START: begin
                    state_next = ST_ACK;
                end
                ST_ACK: begin
                    if (obstacle_working) begin
                        state_next = ST_RUN;
                    end else if (count_reg == ACK_LAST) begin
                        state_next   = ST_IDLE;
                        timeout_next = 1'b1;
                    end
                end
                ST_RUN: begin
                    // A done in the last allowed cycle still counts.
                    if (obstacle_done) begin
                        round_next = round_inc;
                        state_next = (round_inc == ROUNDS_WIN) ? ST_WON : ST_GAP;
                    end else if (count_reg == RUN_LAST) begin
                        state_next   = ST_IDLE;
                        timeout_next = 1'b1;
                    end
                end
                ST_WON: begin
                    state_next = ST_WON;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        // Every state change restarts the phase counter.
        if (state_next != state_reg) begin
            count_next = '0;
        end

        // IDLE always holds a cleared round count and counter.
        if (state_next == ST_IDLE) begin
            round_next = '0;
            count_next = '0;
        end
    end

    assign selected    = selected_reg;
    assign start       = start_reg;
    assign round       = round_reg;
    assign busy        = busy_reg;
    assign game_won    = won_reg;
    assign timeout_err = timeout_reg;

endmodule

// File: tb/tb_obstacle_sequencer.sv
// -----------------------------------------------------------------------------
// tb_obstacle_sequencer
//
// Bench for obstacle_sequencer with NUM_OBSTACLES=4, ROUNDS=3, GAP_CYCLES=4,
// ACK_CYCLES=8, TIMEOUT_CYCLES=100. A behavioural obstacle answers each start
// pulse. A game-level reference model predicts every output on every cycle.
// Directed scenarios pin the key timings with literal values, and a
// randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_obstacle_sequencer;

    localparam int NOBS    = 4;
    localparam int NROUNDS = 3;
    localparam int GAP     = 4;
    localparam int ACKW    = 8;
    localparam int RUNW    = 100;

    logic       pclk;
    logic       rst;
    logic       play_selected;
    logic       menu_on;
    logic       obstacle_done;
    logic       obstacle_working;
    logic [3:0] selected;
    logic       start;
    logic [7:0] round;
    logic       busy;
    logic       game_won;
    logic       timeout_err;

    obstacle_sequencer #(
        .NUM_OBSTACLES  (NOBS),
        .ROUNDS         (NROUNDS),
        .GAP_CYCLES     (GAP),
        .ACK_CYCLES     (ACKW),
        .TIMEOUT_CYCLES (RUNW),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .pclk             (pclk),
        .rst              (rst),
        .play_selected    (play_selected),
        .menu_on          (menu_on),
        .obstacle_done    (obstacle_done),
        .obstacle_working (obstacle_working),
        .selected         (selected),
        .start            (start),
        .round            (round),
        .busy             (busy),
        .game_won         (game_won),
        .timeout_err      (timeout_err)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Game-level reference model. Phases are tracked by how long the game has
    // spent in the current phase; each phase has a fixed allowed length.
    // -------------------------------------------------------------------------
    localparam int P_IDLE = 0, P_GAP = 1, P_START = 2, P_ACK = 3, P_RUN = 4, P_WON = 5;

    int         m_phase   = P_IDLE;
    int         m_elapsed = 0;
    logic [7:0] m_lfsr    = 8'hA5;
    int         m_sel     = 0;
    int         m_round   = 0;
    int         m_terr    = 0;

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic model_step(input bit r, input bit p, input bit m, input bit d, input bit w);
        bit abort;
        int cand;
        int nxt;
        if (r) begin
            m_phase   = P_IDLE;
            m_elapsed = 0;
            m_lfsr    = 8'hA5;
            m_sel     = 0;
            m_round   = 0;
            m_terr    = 0;
        end else begin
            abort = m || !p;
            cand  = int'(m_lfsr[3:0]) % NOBS;
            if (cand == m_sel) cand = (cand + 1) % NOBS;
            nxt = m_phase;
            if (m_phase != P_IDLE && abort) begin
                nxt = P_IDLE;
            end else if (m_phase == P_IDLE) begin
                if (!abort) begin
                    nxt    = P_GAP;
                    m_terr = 0;
                end
            end else if (m_phase == P_GAP) begin
                if (m_elapsed == GAP - 1) begin
                    nxt   = P_START;
                    m_sel = cand;
                end
            end else if (m_phase == P_START) begin
                nxt = P_ACK;
            end else if (m_phase == P_ACK) begin
                if (w) nxt = P_RUN;
                else if (m_elapsed == ACKW - 1) begin
                    nxt    = P_IDLE;
                    m_terr = 1;
                end
            end else if (m_phase == P_RUN) begin
                if (d) begin
                    m_round = m_round + 1;
                    nxt = (m_round == NROUNDS) ? P_WON : P_GAP;
                end else if (m_elapsed == RUNW - 1) begin
                    nxt    = P_IDLE;
                    m_terr = 1;
                end
            end
            if (nxt == P_IDLE) m_round = 0;
            m_elapsed = (nxt == m_phase) ? m_elapsed + 1 : 0;
            m_phase   = nxt;
            m_lfsr    = lfsr_adv(m_lfsr);
        end
    endtask

    // Model advance on the edge, comparison half a cycle later.
    initial begin
        forever begin
            @(posedge pclk);
            model_step(rst, play_selected, menu_on, obstacle_done, obstacle_working);
            @(negedge pclk);
            if (start === 1'b1) n_starts++;
            check("selected",    int'(selected),    m_sel);
            check("start",       int'(start),       int'(m_phase == P_START));
            check("round",       int'(round),       m_round);
            check("busy",        int'(busy),        int'(m_phase != P_IDLE && m_phase != P_WON));
            check("game_won",    int'(game_won),    int'(m_phase == P_WON));
            check("timeout_err", int'(timeout_err), m_terr);
        end
    end

    // -------------------------------------------------------------------------
    // Behavioural obstacle: working from 2 cycles after start until done,
    // done cur_delay cycles after start (0 = never). Restarts on each start.
    // -------------------------------------------------------------------------
    bit obs_random     = 0;
    bit obs_ack_en     = 1;
    int obs_done_delay = 22;

    initial begin
        bit obs_rst;
        int obs_age;
        bit cur_ack;
        int cur_delay;
        obs_age   = -1;
        cur_ack   = 1;
        cur_delay = 22;
        obstacle_working = 1'b0;
        obstacle_done    = 1'b0;
        forever begin
            @(posedge pclk);
            obs_rst = rst;
            @(negedge pclk);
            if (obs_rst) begin
                obs_age = -1;
            end else if (start === 1'b1) begin
                obs_age = 0;
                if (obs_random) begin
                    cur_ack   = ($urandom_range(9) != 0);
                    cur_delay = $urandom_range(110, 3);
                end else begin
                    cur_ack   = obs_ack_en;
                    cur_delay = obs_done_delay;
                end
            end else if (obs_age >= 0 && obs_age < 100000) begin
                obs_age++;
            end
            obstacle_working = cur_ack && (obs_age >= 2) && (cur_delay == 0 || obs_age <= cur_delay);
            obstacle_done    = cur_ack && (cur_delay != 0) && (obs_age == cur_delay);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (all called at a falling edge)
    // -------------------------------------------------------------------------
    task automatic wait_start(input int limit, output int at);
        at = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge pclk);
            if (start === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_start at cycle %0d: got no start, expected one within %0d cycles", cyc, limit);
        end
    endtask

    task automatic reset_seq();
        rst           = 1'b1;
        play_selected = 1'b0;
        menu_on       = 1'b0;
        @(negedge pclk);
        rst = 1'b0;
        check("rst_selected",    int'(selected),    0);
        check("rst_start",       int'(start),       0);
        check("rst_round",       int'(round),       0);
        check("rst_busy",        int'(busy),        0);
        check("rst_game_won",    int'(game_won),    0);
        check("rst_timeout_err", int'(timeout_err), 0);
        @(negedge pclk);
        @(negedge pclk);
    endtask

    task automatic settle();
        play_selected = 1'b0;
        menu_on       = 1'b0;
        repeat (3) @(negedge pclk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected end of test", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, t, e, c0, n0, prev_sel, first_sel;
        rst           = 1'b1;
        play_selected = 1'b0;
        menu_on       = 1'b0;
        @(negedge pclk);
        reset_seq();

        // ---- Normal game with gap timing ----
        obs_ack_en     = 1;
        obs_done_delay = 22;
        n0             = n_starts;
        play_selected  = 1'b1;
        c0             = cyc;
        wait_start(20, s);
        check("gap_first", s - c0, 5);
        first_sel = m_sel;
        prev_sel  = int'(selected);
        for (int r = 1; r <= NROUNDS; r++) begin
            repeat (22) @(negedge pclk);
            t = cyc;
            @(negedge pclk);
            check("round_step", int'(round), r);
            if (r < NROUNDS) begin
                wait_start(20, s);
                check("gap_next", s - t, 5);
                check("no_repeat", int'(int'(selected) != prev_sel), 1);
                prev_sel = int'(selected);
            end else begin
                check("won_flag", int'(game_won), 1);
                check("won_busy", int'(busy), 0);
            end
        end
        repeat (30) @(negedge pclk);
        #1;
        check("start_count", n_starts - n0, 3);
        check("won_hold", int'(round), 3);
        settle();

        // ---- Ack timeout ----
        obs_ack_en    = 0;
        play_selected = 1'b1;
        wait_start(20, s);
        e = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge pclk);
            if (timeout_err === 1'b1) begin
                e = cyc;
                play_selected = 1'b0;
                break;
            end
        end
        check("ack_timeout_seen", int'(e >= 0), 1);
        check("ack_timeout_round", int'(round), 0);
        check("ack_timeout_busy", int'(busy), 0);
        n0 = n_starts;
        repeat (20) @(negedge pclk);
        #1;
        check("ack_no_restart", n_starts - n0, 0);
        check("ack_sticky", int'(timeout_err), 1);
        obs_ack_en = 1;
        settle();

        // ---- Run timeout: done withheld ----
        obs_done_delay = 0;
        play_selected  = 1'b1;
        wait_start(20, s);
        e = -1;
        for (int i = 0; i < 150; i++) begin
            @(negedge pclk);
            if (timeout_err === 1'b1) begin
                e = cyc;
                play_selected = 1'b0;
                break;
            end
        end
        // RUN begins 3 cycles after start; run cycle 100 is start + 103.
        check("run_timeout_cycle", e - s, 103);
        check("run_timeout_round", int'(round), 0);
        settle();

        // ---- Done on run cycle 99 beats the timeout ----
        obs_done_delay = 102;
        play_selected  = 1'b1;
        wait_start(20, s);
        repeat (103) @(negedge pclk);
        check("late_done_round", int'(round), 1);
        check("late_done_terr", int'(timeout_err), 0);
        check("late_done_busy", int'(busy), 1);
        settle();

        // ---- Abort in the same cycle as the winning done ----
        obs_done_delay = 22;
        play_selected  = 1'b1;
        wait_start(20, s);
        repeat (23) @(negedge pclk);
        wait_start(20, s);
        repeat (23) @(negedge pclk);
        check("abort_pre_round", int'(round), 2);
        wait_start(20, s);
        repeat (22) @(negedge pclk);
        menu_on = 1'b1;
        @(negedge pclk);
        check("abort_round", int'(round), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_won", int'(game_won), 0);
        settle();

        // ---- Reset mid-RUN reproduces the first game's first pick ----
        play_selected = 1'b1;
        wait_start(20, s);
        repeat (10) @(negedge pclk);
        reset_seq();
        play_selected = 1'b1;
        c0 = cyc;
        wait_start(20, s);
        check("reset_gap", s - c0, 5);
        check("reset_first_sel", int'(selected), first_sel);
        settle();

        // ---- Randomized phase ----
        obs_random = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge pclk);
            rst = ($urandom_range(999) < 2);
            if (play_selected) begin
                if ($urandom_range(999) < 4) play_selected = 1'b0;
            end else begin
                if ($urandom_range(99) < 6) play_selected = 1'b1;
            end
            menu_on = ($urandom_range(299) < 1);
        end
        rst = 1'b0;
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
